// File: rtl/ip_uart_pkg.sv
// Shared definitions for the transmit-only UART.
//   uart_state_e    : frame sequencing states
//   CLK_DIV_DEFAULT : clk cycles per bit at 21.477 MHz / 115200 baud
//   BIT_IDX_W       : width of the data-bit index (8 data bits)
//   cnt_width()     : baud counter width for a given divider
package ip_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int unsigned CLK_DIV_DEFAULT = 186;
  localparam int unsigned BIT_IDX_W       = 3;

  // Counter holds CLK_DIV-1 down to 0; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ip_uart_baud_cnt.sv
// Bit-period down-counter for ip_uart.
//   clk      : system clock
//   n_reset  : synchronous active-low reset
//   reload   : restart the bit period (frame accept)
//   run      : count while a frame is in progress
//   bit_end  : one-cycle pulse in the last cycle of each bit period
module ip_uart_baud_cnt
  import ip_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic n_reset,
  input  logic reload,
  input  logic run,
  output logic bit_end
);

  localparam int unsigned   CntW   = cnt_width(CLK_DIV);
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Zero while running marks the final cycle of a bit; the edge that
  // consumes bit_end also reloads, so every bit lasts exactly CLK_DIV cycles.
  assign bit_end = run && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (reload || bit_end) begin
      cnt_d = Reload;
    end else if (run) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ip_uart.sv
// Transmit-only 8N1 UART, LSB first.
//   clk        : system clock
//   n_reset    : synchronous active-low reset
//   send_data  : byte to send, captured on the accept edge only
//   send_req   : level-sampled request; accepted when not busy
//   send_busy  : high from the accept edge until the stop bit ends
//   uart_tx    : serial line, idle high (registered)
module ip_uart
  import ip_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] send_data,
  input  logic       send_req,
  output logic       send_busy,
  output logic       uart_tx
);

  uart_state_e            state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   accept;
  logic                   bit_end;

  assign accept = send_req && !busy_q;

  ip_uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_cnt (
    .clk     (clk),
    .n_reset (n_reset),
    .reload  (accept),
    .run     (busy_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = ST_START;
          shift_d   = send_data;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == '1) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign send_busy = busy_q;
  assign uart_tx   = tx_q;

endmodule

// File: tb/tb_ip_uart.sv
module tb_ip_uart;

  localparam int DIV    = 186;
  localparam int FRAME  = 10 * DIV;
  localparam int DIV4   = 4;
  localparam int FRAME4 = 10 * DIV4;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] send_data;
  logic       send_req;
  logic       send_busy;
  logic       uart_tx;
  logic [7:0] send_data4;
  logic       send_req4;
  logic       send_busy4;
  logic       uart_tx4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_q[$];
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  ip_uart #(
    .CLK_DIV (DIV)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .send_data (send_data),
    .send_req  (send_req),
    .send_busy (send_busy),
    .uart_tx   (uart_tx)
  );

  ip_uart #(
    .CLK_DIV (DIV4)
  ) dut4 (
    .clk       (clk),
    .n_reset   (n_reset),
    .send_data (send_data4),
    .send_req  (send_req4),
    .send_busy (send_busy4),
    .uart_tx   (uart_tx4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Busy rising edges mark accepted frames; record the accept-edge cycle.
  always @(negedge clk) begin
    if (send_busy === 1'b1 && busy_prev === 1'b0) acc_q.push_back(cyc);
    busy_prev <= send_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level t cycles after the accept edge: start, d[0..7], stop.
  function automatic logic exp_line(input logic [7:0] d, input int t, input int div);
    int slot;
    slot = t / div;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return d[slot-1];
  endfunction

  // Called at a negedge with busy=0. Optionally pulses a request mid-frame
  // (mid_t) or resets the block mid-frame (abort_t).
  task automatic run_frame(input logic [7:0] d, input int mid_t, input int abort_t);
    int errs;
    int first_bad;
    logic [7:0] dec;
    errs = 0;
    first_bad = -1;
    dec = '0;
    send_data = d;
    send_req  = 1'b1;
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      if (t == mid_t) begin
        send_req  = 1'b1;
        send_data = 8'h55;
      end else begin
        send_req  = 1'b0;
        send_data = 8'($urandom);
      end
      if (t == 0) check("busy_rise", 32'(send_busy), 32'd1);
      if (uart_tx !== exp_line(d, t, DIV) || send_busy !== 1'b1) begin
        errs++;
        if (first_bad < 0) first_bad = t;
      end
      if (t / DIV >= 1 && t / DIV <= 8 && t % DIV == DIV / 2) dec[t / DIV - 1] = uart_tx;
      if (t == abort_t) begin
        n_reset = 1'b0;
        @(negedge clk);
        check("abort_tx", 32'(uart_tx), 32'd1);
        check("abort_busy", 32'(send_busy), 32'd0);
        n_reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
    check("busy_fall", 32'(send_busy), 32'd0);
    check("stop_idle_tx", 32'(uart_tx), 32'd1);
    if (errs != 0) $display("first bad wave cycle %0d for byte %h", first_bad, d);
    check("wave_errs", 32'(errs), 32'd0);
    check("decoded", 32'(dec), 32'(d));
  endtask

  task automatic run_frame4(input logic [7:0] d);
    int errs;
    int hi_cnt;
    errs = 0;
    hi_cnt = 0;
    send_data4 = d;
    send_req4  = 1'b1;
    for (int t = 0; t < FRAME4; t++) begin
      @(negedge clk);
      send_req4  = 1'b0;
      send_data4 = 8'($urandom);
      if (uart_tx4 !== exp_line(d, t, DIV4) || send_busy4 !== 1'b1) errs++;
      if (t >= 32 && t <= 35 && uart_tx4 === 1'b1) hi_cnt++;
    end
    @(negedge clk);
    check("div4_busy_fall", 32'(send_busy4), 32'd0);
    check("div4_wave_errs", 32'(errs), 32'd0);
    if (d == 8'h80) check("div4_d7_window", 32'(hi_cnt), 32'd4);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || send_busy !== 1'b0) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] bytes3 [7];
    bytes3 = '{8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    // Reset with a request held: no start bit may appear.
    n_reset    = 1'b0;
    send_req   = 1'b1;
    send_data  = 8'h00;
    send_req4  = 1'b0;
    send_data4 = 8'h00;
    @(negedge clk);
    check("rst_tx_0", 32'(uart_tx), 32'd1);
    check("rst_busy_0", 32'(send_busy), 32'd0);
    @(negedge clk);
    check("rst_tx_1", 32'(uart_tx), 32'd1);
    check("rst_busy_1", 32'(send_busy), 32'd0);
    n_reset  = 1'b1;
    send_req = 1'b0;
    idle_check("post_reset_idle", 4);

    // Single byte.
    run_frame(8'h12, -1, -1);

    // Back-to-back frames, each requested the cycle busy is seen low.
    acc_q.delete();
    foreach (bytes3[i]) run_frame(bytes3[i], -1, -1);
    check("b2b_accepts", 32'(acc_q.size()), 32'd7);
    for (int i = 1; i < acc_q.size(); i++)
      check("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'(FRAME + 1));

    // Request while busy is dropped, not queued.
    run_frame(8'hAA, FRAME / 2, -1);
    idle_check("no_queue", 8);

    // Reset during data bit 3, then a clean frame.
    run_frame(8'hFF, -1, 4 * DIV + DIV / 2);
    run_frame(8'h0F, -1, -1);

    // Random bytes with random idle gaps and random mid-frame requests.
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(8'($urandom), int'($urandom_range(1, FRAME - 2)), -1);
    end

    // Short divider.
    run_frame4(8'h80);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame4(8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
